obstacle_lane: RTL and testbench

Multi-slot obstacle scroller for the Dino game's VGA path. It tracks up to SLOTS independent cactus sprites moving right-to-left across the ground band, accepts spawn requests through a req/ack handshake, and advances every active obstacle by a programmable speed once per frame. For each scanned pixel it outputs, with a fixed 1-cycle latency, a hit flag, the winning slot and the sprite ROM address. The sprite ROM and colour mux sit downstream; no hit means white (12'hfff).

---
 rtl/obstacle_lane.sv | 156 +++++++++++++++
 tb/tb_obstacle_lane.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_lane.sv
// obstacle_lane: multi-slot cactus scroller for the Dino game's VGA path.
// It keeps up to SLOTS obstacles moving right-to-left across the ground band.
// New obstacles are spawned through a req/ack handshake. On each frame tick
// (while running), every active obstacle advances by 'speed' columns. Every
// scanned pixel is then classified with a fixed 1-cycle latency.
//
// Ports:
//   clk, rst_n         clock; synchronous active-low reset
//   frame_tick, run    advance active obstacles once per frame while run=1
//   speed              columns advanced per frame
//   spawn_req          request a new obstacle
//   spawn_ack          one-cycle pulse when a request is accepted
//   spawn_full         every slot is occupied
//   col_addr, row_addr scanned pixel
//   pix_hit            pixel lies inside an active obstacle (registered)
//   pix_slot           lowest-index slot covering the pixel (registered)
//   sprite_addr        sprite ROM address of the pixel (registered)
//   cleared_cnt        saturating count of obstacles scrolled off screen
module obstacle_lane #(
    parameter int SLOTS       = 4,
    parameter int COLNUM      = 640,
    parameter int LENGTH      = 60,
    parameter int HEIGHT      = 80,
    parameter int ROW_HIGHEST = 130,
    parameter int MIN_GAP     = 200,
    parameter int SPEED_W     = 4,
    parameter int ADDR_W      = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               run,
    input  logic [SPEED_W-1:0] speed,
    input  logic               spawn_req,
    output logic               spawn_ack,
    output logic               spawn_full,
    input  logic [9:0]         col_addr,
    input  logic [8:0]         row_addr,
    output logic               pix_hit,
    output logic [2:0]         pix_slot,
    output logic [ADDR_W-1:0]  sprite_addr,
    output logic [15:0]        cleared_cnt
);

    localparam logic [11:0] END_C    = 12'(COLNUM + LENGTH);
    localparam logic [11:0] COL_C    = 12'(COLNUM);
    localparam logic [11:0] GAP_C    = 12'(MIN_GAP);
    localparam logic [9:0]  ROW_LO_C = 10'(ROW_HIGHEST - HEIGHT + 1);
    localparam logic [9:0]  ROW_HI_C = 10'(ROW_HIGHEST);
    localparam logic [19:0] LEN_C    = 20'(LENGTH);

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [SLOTS-1:0] active, active_nx;
    logic [10:0]      count    [SLOTS];
    logic [10:0]      count_nx [SLOTS];
    logic [2:0]       newest;
    logic             newest_vld;

    logic             adv, free_found, gap_ok, accept;
    logic [2:0]       free_idx;
    logic [3:0]       retire_n;

    logic             row_ok;
    logic [11:0]      psum;
    logic             hit_p0;
    logic [2:0]       slot_p0;
    logic [ADDR_W-1:0] addr_p0;

    // Slot update: frame advance, retirement and spawn acceptance, all
    // judged against the state held before the edge.
    always_comb begin
        adv        = frame_tick && run;
        active_nx  = active;
        count_nx   = count;
        retire_n   = 4'd0;
        free_found = 1'b0;
        free_idx   = 3'd0;
        gap_ok     = 1'b1;
        for (int i = 0; i < SLOTS; i++) begin
            if (!active[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = 3'(i);
            end
            if (newest_vld && newest == 3'(i) && active[i] && {1'b0, count[i]} < GAP_C)
                gap_ok = 1'b0;
            if (adv && active[i]) begin
                count_nx[i] = count[i] + 11'(speed);
                if ({1'b0, count_nx[i]} >= END_C) begin
                    active_nx[i] = 1'b0;
                    retire_n     = retire_n + 4'd1;
                end
            end
        end
        accept = spawn_req && !spawn_ack && free_found && gap_ok;
        // A freshly spawned slot was inactive, so it was never advanced above.
        for (int i = 0; i < SLOTS; i++) begin
            if (accept && free_idx == 3'(i)) begin
                active_nx[i] = 1'b1;
                count_nx[i]  = 11'd0;
            end
        end
    end

    // Pixel classification (stage p0), scanned high-to-low so the lowest
    // hitting slot is the one left standing.
    always_comb begin
        hit_p0  = 1'b0;
        slot_p0 = 3'd0;
        addr_p0 = '0;
        psum    = 12'd0;
        row_ok  = ({1'b0, row_addr} >= ROW_LO_C) && ({1'b0, row_addr} <= ROW_HI_C);
        for (int i = SLOTS - 1; i >= 0; i--) begin
            psum = {1'b0, count[i]} + {2'b00, col_addr};
            if (active[i] && row_ok && psum >= COL_C && psum < END_C) begin
                hit_p0  = 1'b1;
                slot_p0 = 3'(i);
                addr_p0 = ADDR_W'((20'(row_addr) - 20'(ROW_LO_C)) * LEN_C + 20'(psum - COL_C));
            end
        end
    end

    // Register boundary: slot state and the p1 pixel outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active      <= '0;
            for (int i = 0; i < SLOTS; i++) count[i] <= 11'd0;
            newest      <= 3'd0;
            newest_vld  <= 1'b0;
            spawn_ack   <= 1'b0;
            spawn_full  <= 1'b0;
            cleared_cnt <= 16'd0;
            pix_hit     <= 1'b0;
            pix_slot    <= 3'd0;
            sprite_addr <= '0;
        end else begin
            active      <= active_nx;
            for (int i = 0; i < SLOTS; i++) count[i] <= count_nx[i];
            if (accept) begin
                newest     <= free_idx;
                newest_vld <= 1'b1;
            end
            spawn_ack   <= accept;
            spawn_full  <= &active_nx;
            cleared_cnt <= sat_add16(cleared_cnt, retire_n);
            pix_hit     <= hit_p0;
            pix_slot    <= slot_p0;
            sprite_addr <= addr_p0;
        end
    end

endmodule

// File: tb/tb_obstacle_lane.sv
// Bench for obstacle_lane: a default instance (MIN_GAP=200) and a second
// instance with MIN_GAP=0 share all inputs; each scenario inspects the
// instance it targets. Pixel expectations go through a scoreboard queue.
module tb_obstacle_lane;

    logic        clk = 1'b0;
    logic        rst_n, frame_tick, run, spawn_req;
    logic [3:0]  speed;
    logic [9:0]  col_addr;
    logic [8:0]  row_addr;

    logic        ack_a, full_a, hit_a, ack_b, full_b, hit_b;
    logic [2:0]  slot_a, slot_b;
    logic [12:0] addr_a, addr_b;
    logic [15:0] clr_a, clr_b;

    int checks = 0;
    int errors = 0;
    logic pix_vld = 1'b0;

    typedef struct {
        bit         sel;
        bit         hit;
        logic [2:0] slot;
        logic [12:0] addr;
    } pexp_t;
    pexp_t exp_q[$];

    typedef struct {
        logic [9:0]  col;
        logic [8:0]  row;
        bit          hit;
        logic [2:0]  slot;
        logic [12:0] addr;
    } vec_t;
    vec_t basic[8];

    obstacle_lane u_dut_a (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .speed(speed),
        .spawn_req(spawn_req), .spawn_ack(ack_a), .spawn_full(full_a),
        .col_addr(col_addr), .row_addr(row_addr), .pix_hit(hit_a), .pix_slot(slot_a),
        .sprite_addr(addr_a), .cleared_cnt(clr_a)
    );

    obstacle_lane #(.MIN_GAP(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .speed(speed),
        .spawn_req(spawn_req), .spawn_ack(ack_b), .spawn_full(full_b),
        .col_addr(col_addr), .row_addr(row_addr), .pix_hit(hit_b), .pix_slot(slot_b),
        .sprite_addr(addr_b), .cleared_cnt(clr_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        spawn_req  = 1'b0;
        frame_tick = 1'b0;
        run        = 1'b1;
        rst_n      = 1'b0;
        step();
        rst_n      = 1'b1;
    endtask

    task automatic do_spawn(input bit which);
        bit got;
        got = 1'b0;
        spawn_req = 1'b1;
        for (int k = 0; k < 8 && !got; k++) begin
            step();
            got = which ? ack_b : ack_a;
        end
        spawn_req = 1'b0;
        check("spawn_ack", got, 1);
    endtask

    // Present one pixel for one cycle and queue the outcome expected one cycle later.
    task automatic pix(input bit sel, input int col, input int row,
                       input bit hit, input int slot, input int addr);
        pexp_t e;
        e.sel  = sel;
        e.hit  = hit;
        e.slot = 3'(slot);
        e.addr = 13'(addr);
        col_addr = 10'(col);
        row_addr = 9'(row);
        exp_q.push_back(e);
        pix_vld = 1'b1;
        step();
        pix_vld = 1'b0;
    endtask

    // Scoreboard: a pixel presented before an edge is compared after that edge.
    initial begin
        logic v;
        pexp_t e;
        forever begin
            @(posedge clk);
            v = pix_vld;
            @(negedge clk);
            if (v) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_hit",     e.sel ? hit_b  : hit_a,  e.hit);
                    check("pix_slot",    e.sel ? slot_b : slot_a, e.slot);
                    check("sprite_addr", e.sel ? addr_b : addr_a, e.addr);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        basic[0] = '{10'd636, 9'd51,  1'b1, 3'd0, 13'd0};
        basic[1] = '{10'd695, 9'd130, 1'b1, 3'd0, 13'd4799};
        basic[2] = '{10'd696, 9'd130, 1'b0, 3'd0, 13'd0};
        basic[3] = '{10'd636, 9'd50,  1'b0, 3'd0, 13'd0};
        basic[4] = '{10'd640, 9'd100, 1'b1, 3'd0, 13'd2944};
        basic[5] = '{10'd635, 9'd51,  1'b0, 3'd0, 13'd0};
        basic[6] = '{10'd636, 9'd131, 1'b0, 3'd0, 13'd0};
        basic[7] = '{10'd660, 9'd80,  1'b1, 3'd0, 13'd1764};

        rst_n = 1'b0; frame_tick = 1'b0; run = 1'b1; spawn_req = 1'b0;
        speed = 4'd0; col_addr = 10'd0; row_addr = 9'd0;
        step(); step();
        rst_n = 1'b1;

        // Reset state
        check("rst_ack",   ack_a,  0);
        check("rst_full",  full_a, 0);
        check("rst_clr",   clr_a,  0);
        check("rst_hit",   hit_a,  0);
        check("rst_slot",  slot_a, 0);
        check("rst_addr",  addr_a, 0);

        // Basic draw: one obstacle at count 4, pixels streamed back to back
        speed = 4'd4;
        do_spawn(0);
        tick(1);
        for (int i = 0; i < 8; i++)
            pix(0, basic[i].col, basic[i].row, basic[i].hit, basic[i].slot, basic[i].addr);

        // Retire, including frozen ticks while run=0
        do_reset();
        speed = 4'd10;
        do_spawn(0);
        step();
        check("ack_pulse", ack_a, 0);
        run = 1'b0;
        tick(5);
        run = 1'b1;
        tick(65);
        pix(0, 0, 51, 1, 0, 10);
        check("clr_before", clr_a, 0);
        tick(5);
        check("clr_retire",  clr_a, 1);
        check("full_retire", full_a, 0);
        pix(0, 0, 51, 0, 0, 0);
        pix(0, 640, 51, 0, 0, 0);
        do_spawn(0);
        pix(0, 640, 51, 1, 0, 0);

        // Gap / full with spawn_req held continuously
        do_reset();
        speed = 4'd10;
        spawn_req = 1'b1;
        step();
        check("gap_ack0", ack_a, 1);
        for (int t = 1; t <= 80; t++) begin
            tick(1);
            step();
            check($sformatf("gap_ack_t%0d", t), ack_a, (t % 20 == 0) ? 1 : 0);
            check($sformatf("gap_full_t%0d", t), full_a,
                  ((t >= 60 && t < 70) || t >= 80) ? 1 : 0);
            if (t == 60)      pix(0, 640, 51, 1, 3, 0);
            else if (t == 80) pix(0, 640, 51, 1, 0, 0);
            else              step();
        end
        spawn_req = 1'b0;

        // Spawn request coinciding with slot 0 retiring (MIN_GAP=0 instance)
        do_reset();
        speed = 4'd10;
        do_spawn(1);
        tick(10);
        do_spawn(1); do_spawn(1); do_spawn(1);
        check("sim_full", full_b, 1);
        tick(59);
        spawn_req  = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("sim_ack_withheld", ack_b, 0);
        check("sim_full_freed",   full_b, 0);
        step();
        spawn_req = 1'b0;
        check("sim_ack_next", ack_b, 1);
        check("sim_full_again", full_b, 1);
        pix(1, 640, 51, 1, 0, 0);

        // Overlap: lowest-index slot wins
        do_reset();
        speed = 4'd1;
        do_spawn(1);
        tick(1);
        do_spawn(1);
        pix(1, 640, 60, 1, 0, 541);
        pix(1, 639, 60, 1, 0, 540);
        pix(1, 699, 60, 1, 1, 599);

        // Reset mid-operation
        do_reset();
        speed = 4'd15;
        do_spawn(1); do_spawn(1); do_spawn(1); do_spawn(1);
        tick(47);
        check("mid_clr4", clr_b, 4);
        do_spawn(1);
        tick(47);
        check("mid_clr5", clr_b, 5);
        do_spawn(1); do_spawn(1); do_spawn(1);
        tick(2);
        pix(1, 610, 51, 1, 0, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_ack",  ack_b,  0);
        check("mid_rst_full", full_b, 0);
        check("mid_rst_clr",  clr_b,  0);
        check("mid_rst_hit",  hit_b,  0);
        check("mid_rst_slot", slot_b, 0);
        check("mid_rst_addr", addr_b, 0);
        pix(1, 610, 51, 0, 0, 0);
        do_spawn(1);
        pix(1, 640, 51, 1, 0, 0);

        step(); step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
